mult_seq_param: RTL
===================

// Module: mult_seq_param
// PURPOSE
//  Parametrised sequential multiplier for WIDTH x WIDTH operands, signed or unsigned.
//  Splits each operand into CHUNK-bit digits and accumulates one CHUNKxCHUNK partial product
//  per cycle into a 2*WIDTH result, so one small multiplier serves any operand width.
//  Adds a per-operation signed mode and a done pulse.
//  Sits behind a start/busy handshake as a drop-in arithmetic unit for datapath controllers.
// PARAMETERS
//  WIDTH  32  operand width in bits; must be a multiple of CHUNK
//  CHUNK  16  digit width of the internal multiplier, >= 2; N = WIDTH/CHUNK digits
// PORTS
//  clk      in   1        rising-edge clock
//  reset    in   1        asynchronous, active-low reset (0 = reset)
//  start    in   1        request; accepted only when busy==0
//  is_signed in  1        1: a, b two's complement; 0: unsigned; sampled with start
//  a        in   WIDTH    multiplicand, sampled with start
//  b        in   WIDTH    multiplier, sampled with start
//  busy     out  1        operation in progress
//  done     out  1        one-cycle pulse: product holds a new result
//  product  out  2*WIDTH  result register
// BEHAVIOUR
//  - Reset (reset==0, async, any state): FSM->IDLE, busy=0, done=0, product=0, internal regs=0.
//    An in-flight operation is discarded; no done is produced for it.
//  - FSM states IDLE, RUN, FIX.
//    IDLE: start==1 -> latch |a|,|b| (magnitudes when is_signed, else raw),
//      latch result sign = is_signed & (a[MSB]^b[MSB]), clear accumulator, digit idx i=j=0 -> RUN.
//    RUN: each cycle acc += (a_dig[i]*b_dig[j]) << CHUNK*(i+j); step j, then i;
//      after N*N partial products -> FIX.
//    FIX: acc negated if result sign set; -> IDLE, product<=acc, done<=1, busy<=0 on that edge.
//  - Latency: busy=1 for exactly N*N+1 cycles after the accepting edge (5 at defaults);
//    done=1 on the following cycle with busy=0 and product valid.
//  - done is high for one cycle only; product holds its value until the next completion.
//  - start while busy==1 is ignored (no queuing); operand changes while busy have no effect.
//  - start in the same cycle as done==1 is accepted (busy is 0).
//  - Width: magnitudes are WIDTH-bit unsigned (|-2^(WIDTH-1)| = 2^(WIDTH-1) fits);
//    accumulator 2*WIDTH bits, never overflows; result exact in both modes.
//  - Zero operands follow the normal path (no early exit); latency is data-independent.
// STRUCTURE
//  - Package mult_seq_pkg: typedef enum logic [1:0] {IDLE, RUN, FIX} mult_state_t;
//    function clog2-based digit-counter width helper.
//  - Sub-module mult_chunk: combinational CHUNK x CHUNK unsigned multiplier, 2*CHUNK out;
//    one instance; digit selection, shift, accumulate and FSM live in mult_seq_param.
//  - Elaboration check: $error if WIDTH % CHUNK != 0 or CHUNK < 2.
// TESTING (defaults WIDTH=32, CHUNK=16; clk period 2, reset low 4 periods)
//  1 unsigned: a=309518561, b=316276955, start 1 cycle -> busy 5 cycles, then done=1,
//    product=97893587989061755.
//  2 signed/unsigned: a=32'hFFFFFFFD, b=7: is_signed=1 -> 64'hFFFFFFFF_FFFFFFEB;
//    is_signed=0 -> 64'h00000006_FFFFFFEB.
//  3 signed extreme: a=b=32'h80000000, is_signed=1 -> 64'h40000000_00000000;
//    a=32'h80000000, b=32'h7FFFFFFF -> 64'hC0000000_80000000.
//  4 handshake: second start (a=2,b=3) mid-busy ignored -> product of first op only;
//    start coincident with done accepted -> next result 6 after 5 busy cycles.
//  5 reset mid-op: drop reset at 3rd busy cycle -> busy=0, done=0, product=0 immediately;
//    no done afterwards; next op after release correct.
//  6 param sweep: WIDTH=24, CHUNK=8 (busy 10 cycles): a=24'hFFFFFF, b=24'hFFFFFF unsigned
//    -> 48'hFFFFFE_000001; zero operand -> product 0, same latency.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared types and sizing helpers for the chunked sequential multiplier.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mult_state_t;

  // Digit index counters need at least one bit even when there is a single digit.
  function automatic int digit_cnt_w(input int n_digits);
    return (n_digits > 1) ? $clog2(n_digits) : 1;
  endfunction

endpackage

// File: rtl/mult_chunk.sv
// Combinational CHUNK x CHUNK unsigned multiplier; the only multiplier in the datapath.
module mult_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0]   a_i,
  input  logic [CHUNK-1:0]   b_i,
  output logic [2*CHUNK-1:0] p_o
);

  assign p_o = {{CHUNK{1'b0}}, a_i} * {{CHUNK{1'b0}}, b_i};

endmodule

// File: rtl/mult_seq_param.sv
// Sequential WIDTH x WIDTH multiplier: one CHUNK x CHUNK partial product per cycle,
// signed operands handled by sign-magnitude conversion around an unsigned core.
module mult_seq_param
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = digit_cnt_w(N);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if ((WIDTH % CHUNK) != 0 || CHUNK < 2) begin : g_bad_param
      $error("mult_seq_param: WIDTH must be a multiple of CHUNK and CHUNK >= 2");
    end
  endgenerate

  mult_state_t      state_q, state_d;
  logic [WIDTH-1:0] a_mag_q, a_mag_d;
  logic [WIDTH-1:0] b_mag_q, b_mag_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    i_q, i_d;
  logic [CW-1:0]    j_q, j_d;
  logic [PW-1:0]    product_q, product_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0]   a_dig;
  logic [CHUNK-1:0]   b_dig;
  logic [2*CHUNK-1:0] pp;
  logic [PW-1:0]      pp_shifted;

  assign a_dig = a_mag_q[i_q*CHUNK +: CHUNK];
  assign b_dig = b_mag_q[j_q*CHUNK +: CHUNK];

  mult_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i (a_dig),
    .b_i (b_dig),
    .p_o (pp)
  );

  // Digit weights add: digit i of a times digit j of b lands at CHUNK*(i+j).
  assign pp_shifted = PW'(pp) << (CHUNK * (32'(i_q) + 32'(j_q)));

  // Handshake: start is taken only on an edge where busy==0; busy stays high from the
  // accepting edge until the result edge, and done pulses for one cycle with product valid.
  always_comb begin
    state_d   = state_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    i_d       = i_q;
    j_d       = j_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_mag_d = (is_signed && a[WIDTH-1]) ? -a : a;
          b_mag_d = (is_signed && b[WIDTH-1]) ? -b : b;
          neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + pp_shifted;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            state_d = FIX;
          end else begin
            i_d = i_q + CW'(1);
          end
        end else begin
          j_d = j_q + CW'(1);
        end
      end
      FIX: begin
        product_d = neg_q ? -acc_q : acc_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      i_q       <= i_d;
      j_q       <= j_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign product = product_q;

endmodule
